mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit of the RISC-V pipeline. It consumes the decoded memory controls (`mem_write`, `mem_store_type`, `wb_load`, `mem_load_type`) together with the EX-stage address and store data. It drives a single-outstanding request/grant/response data-memory port, generating byte enables, lane-replicated write data and sign/zero-extended load data. It stalls the pipeline for the whole bus transaction and flags misaligned accesses.

## Interface

Parameters:
- `XLEN`, 32: data and address width. Only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  memory-stage instruction valid.
- `mem_write`  in  1  store instruction.
- `mem_store_type`  in  2  encoding: SB=00, SH=01, SW=10, DEF=11 (no write).
- `wb_load`  in  1  load instruction.
- `mem_load_type`  in  3  encoding: LB=000, LH=001, LW=010, LBU=011, LHU=100, DEF=111 (full word).
- `addr`  in  32  effective byte address.
- `store_data`  in  32  rs2 value.
- `stall`  out  1  freeze upstream pipeline.
- `resp_valid`  out  1  one-cycle pulse: access complete.
- `load_data`  out  32  extended load result; valid with `resp_valid` on loads.
- `misaligned`  out  1  one-cycle pulse: access rejected.
- `dmem_req`  out  1  bus request.
- `dmem_we`  out  1  write.
- `dmem_addr`  out  32  word address; `addr` with bits [1:0] forced to 00.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated write data.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  32  read word.

## Operation

- **FSM states:** IDLE, REQ, WAIT_R, DONE.
- **Start condition:** in IDLE, `start = in_valid & ((mem_write & mem_store_type!=DEF) | wb_load) & aligned`.
  - The op is captured: addr, type, be, wdata, and is_load.
  - Next state is REQ.
- **Alignment:**
  - SH, LH, LHU require `addr[0]==0`.
  - SW, LW, and load DEF require `addr[1:0]==00`.
  - SB, LB, LBU are always aligned.
- **Misaligned access:** `misaligned=1` for one cycle, no bus activity, FSM stays in IDLE, `stall=0`.
- **Store DEF:** treated as no memory operation.
- **Simultaneous flags:** if both `mem_write` and `wb_load` are set, the load wins.
- **Byte enables:**
  - SB: `0001<<addr[1:0]`.
  - SH: `0011<<{addr[1],1'b0}`.
  - SW: `1111`.
- **Write data:**
  - SB: byte ×4.
  - SH: half ×2.
  - SW: as-is.
- **REQ:**
  - `dmem_req=1`; `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata` come from the captured registers and are held stable until `dmem_gnt`.
  - Loads drive `dmem_be=1111` and `dmem_we=0`.
  - On `dmem_gnt`: a store goes to DONE; a load goes to WAIT_R.
- **WAIT_R:**
  - `dmem_req=0`.
  - On `dmem_rvalid`, register the extracted data and go to DONE.
  - `dmem_rvalid` in any other state is ignored.
- **Load extraction** (lane = captured `addr[1:0]`):
  - LB/LBU: byte sign/zero-extended.
  - LH/LHU: half at `addr[1]`, sign/zero-extended.
  - LW and DEF: full word.
- **DONE:** `resp_valid=1`, `stall=0`; next state is IDLE. No new op is accepted in DONE.
- **Non-memory instruction:** passes with `stall=0` and no outputs asserted.

## Timing

- **Reset:** `rst_n` sampled low at a clock edge forces IDLE.
  - All outputs are 0; `load_data=0`.
  - An in-flight transaction is abandoned, including mid-REQ or mid-WAIT_R.
  - A late `rvalid` after reset is ignored.
- **`stall`** is combinational: `start | (state==REQ) | (state==WAIT_R)`.
  - It asserts in the acceptance cycle.
- **Store latency:** acceptance at cycle N.
  - REQ at N+1.
  - With grant at N+1: DONE at N+2, `resp_valid` at N+2, stall is low from N+2.
- **Load latency:** with grant at N+1 and `rvalid` at N+2, `resp_valid` and `load_data` appear at N+3.
- **Wait states:**
  - Each cycle without `dmem_gnt` adds one cycle in REQ.
  - Each cycle without `dmem_rvalid` adds one cycle in WAIT_R.
- **Outstanding requests:** at most one.
- **Registered outputs:** `load_data` is registered and holds until the next load completes or reset. All bus outputs are registered.

## Structure

- **Shared package `riscv_pkg`:**
  - Opcode and ALU constants.
  - Store-type and load-type encodings (`STORE_*`, `LOAD_*`).
  - FSM state enum `lsu_state_t`.
- **Sub-module `load_align`:** combinational extraction and extension.
  - Inputs: `rdata`, `offset[1:0]`, `load_type`.
  - Output: `data`.
  - It is instantiated once, between `dmem_rdata` and the `load_data` register.
- **Top-level contents:** FSM, capture registers, byte-enable/replication logic.

## Test plan

- **SB:** SB, addr=0x1003, data=0x000000AB, gnt immediate → `dmem_addr`=0x1000, `be`=1000, `wdata`=0xABABABAB, `resp_valid` at N+2, stall high for N and N+1 only.
- **LB / LBU:** LB addr=0x2001, rdata=0x1234_80FF, rvalid after 3 wait cycles → `load_data`=0xFFFFFF80; the same access with LBU → 0x00000080.
- **LH / LHU:** LH addr=0x2002, rdata=0x8001_0000 → 0xFFFF8001; LHU → 0x00008001; SH addr=0x2002, data 0x5566 → `be`=1100, `wdata`=0x55665566.
- **Misalignment:** LW addr=0x3002 and SH addr=0x3001 → `misaligned` pulse, `dmem_req` never asserted, stall=0.
- **Grant stall:** `dmem_gnt` held low for 4 cycles in REQ → req, addr, be, wdata stable throughout, stall high, single `resp_valid` afterwards.
- **Reset mid-load:** `rst_n` low in WAIT_R, then rvalid arrives after release → IDLE, no `resp_valid`, `load_data`=0, stall=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V constants, load/store type encodings, LSU state enum and alignment helpers
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [1:0] STORE_SB  = 2'b00;
  localparam logic [1:0] STORE_SH  = 2'b01;
  localparam logic [1:0] STORE_SW  = 2'b10;
  localparam logic [1:0] STORE_DEF = 2'b11;
  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b011;
  localparam logic [2:0] LOAD_LHU = 3'b100;
  localparam logic [2:0] LOAD_DEF = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} lsu_state_t;
  function automatic logic load_aligned(input logic [2:0] t, input logic [1:0] o);
    return (t == LOAD_LB || t == LOAD_LBU) ? 1'b1 : (t == LOAD_LH || t == LOAD_LHU) ? ~o[0] : (o == 2'b00);
  endfunction
  function automatic logic store_aligned(input logic [1:0] t, input logic [1:0] o);
    return (t == STORE_SB) ? 1'b1 : (t == STORE_SH) ? ~o[0] : (o == 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory req/gnt/rvalid bus; master = LSU (req/we/addr/be/wdata out), slave = memory (gnt/rvalid/rdata out)
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  modport master (output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, input dmem_gnt, dmem_rvalid, dmem_rdata);
  modport slave  (input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, output dmem_gnt, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/mem_access_unit_load_align.sv
// load_align: picks the byte/half lane of rdata at offset and sign/zero-extends per load_type (rdata, offset, load_type in; data out)
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{offset, 3'b000} +: 8];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    data = load_type == LOAD_LB  ? {{24{b[7]}}, b} :
           load_type == LOAD_LBU ? {24'b0, b} :
           load_type == LOAD_LH  ? {{16{h[15]}}, h} :
           load_type == LOAD_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit; pipeline controls in, stall/resp_valid/load_data/misaligned out, dmem bus via interface
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             mem_write,
  input  logic [1:0]       mem_store_type,
  input  logic             wb_load,
  input  logic [2:0]       mem_load_type,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  store_data,
  output logic             stall,
  output logic             resp_valid,
  output logic [XLEN-1:0]  load_data,
  output logic             misaligned,
  mem_access_unit_if.master dmem
);
  lsu_state_t state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q, load_data_q, ext_data, wdata_d;
  logic [3:0] be_q, be_d;
  logic [1:0] off_q;
  logic [2:0] ltype_q;
  logic load_q, is_load, is_store, aligned, req_ok, start;
  assign is_load    = wb_load;
  assign is_store   = mem_write & (mem_store_type != STORE_DEF) & ~wb_load;
  assign aligned    = is_load ? load_aligned(mem_load_type, addr[1:0]) : store_aligned(mem_store_type, addr[1:0]);
  assign req_ok     = rst_n & in_valid & (is_load | is_store) & (state_q == S_IDLE);
  assign start      = req_ok & aligned;
  assign misaligned = req_ok & ~aligned;
  assign stall      = start | (state_q == S_REQ) | (state_q == S_WAIT_R);
  assign resp_valid = state_q == S_DONE;
  assign load_data  = load_data_q;
  always_comb begin
    be_d    = is_load ? 4'b1111 :
              mem_store_type == STORE_SB ? 4'b0001 << addr[1:0] :
              mem_store_type == STORE_SH ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    wdata_d = is_load ? '0 :
              mem_store_type == STORE_SB ? {4{store_data[7:0]}} :
              mem_store_type == STORE_SH ? {2{store_data[15:0]}} : store_data;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = start ? S_REQ : S_IDLE;
      S_REQ:    state_d = dmem.dmem_gnt ? (load_q ? S_WAIT_R : S_DONE) : S_REQ;
      S_WAIT_R: state_d = dmem.dmem_rvalid ? S_DONE : S_WAIT_R;
      default:  state_d = S_IDLE;
    endcase
    dmem.dmem_req   = state_q == S_REQ;
    dmem.dmem_we    = dmem.dmem_req & ~load_q;
    dmem.dmem_addr  = dmem.dmem_req ? addr_q : '0;
    dmem.dmem_be    = dmem.dmem_req ? be_q : '0;
    dmem.dmem_wdata = dmem.dmem_req ? wdata_q : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      off_q       <= '0;
      ltype_q     <= '0;
      load_q      <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q  <= {addr[XLEN-1:2], 2'b00};
        off_q   <= addr[1:0];
        ltype_q <= mem_load_type;
        load_q  <= is_load;
        be_q    <= be_d;
        wdata_q <= wdata_d;
      end
      if (state_q == S_WAIT_R && dmem.dmem_rvalid) load_data_q <= ext_data;
    end
  end
  load_align u_align (
    .rdata    (dmem.dmem_rdata),
    .offset   (off_q),
    .load_type(ltype_q),
    .data     (ext_data)
  );
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with byte-level memory reference model and randomized memory wait states
module tb_mem_access_unit;
  import riscv_pkg::*;
  logic clk = 0, rst_n = 0, in_valid = 0, mem_write = 0, wb_load = 0;
  logic [1:0] mem_store_type = 0;
  logic [2:0] mem_load_type = 0;
  logic [31:0] addr = 0, store_data = 0;
  logic stall, resp_valid, misaligned;
  logic [31:0] load_data;
  mem_access_unit_if bus ();
  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_write(mem_write),
    .mem_store_type(mem_store_type), .wb_load(wb_load), .mem_load_type(mem_load_type),
    .addr(addr), .store_data(store_data), .stall(stall), .resp_valid(resp_valid),
    .load_data(load_data), .misaligned(misaligned), .dmem(bus)
  );
  always #5 clk = ~clk;
  typedef struct {bit mis; logic [31:0] data;} ev_t;
  typedef struct {bit we; logic [31:0] a; logic [3:0] be; logic [31:0] wd;} bus_t;
  ev_t exp_q[$];
  bus_t bus_q[$];
  ev_t me;
  bus_t mb;
  int n_chk = 0, n_err = 0, cyc = 0, ev_cnt = 0, resp_cyc = 0;
  logic [7:0] ref_b[256];
  logic [31:0] mem_w[64];
  logic [31:0] last_ld = 0;
  logic gnt_en = 0;
  int gnt_hold = 0, rv_fix = -1;
  bit gnt_rand = 0, spur = 0;
  assign bus.dmem_gnt = bus.dmem_req & gnt_en;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // memory slave: random grant, random read latency, spurious rvalid when no read is pending
  initial begin
    bit acc, acc_we, pend;
    logic [31:0] acc_a, acc_wd;
    logic [3:0] acc_be;
    logic [5:0] pa;
    int cnt;
    pend = 0; cnt = 0; pa = 0;
    bus.dmem_rvalid = 0;
    bus.dmem_rdata = 0;
    forever begin
      @(negedge clk);
      acc = bus.dmem_req & bus.dmem_gnt & rst_n;
      acc_we = bus.dmem_we; acc_a = bus.dmem_addr; acc_be = bus.dmem_be; acc_wd = bus.dmem_wdata;
      @(posedge clk); #1;
      if (acc && acc_we) for (int k = 0; k < 4; k++) if (acc_be[k]) mem_w[acc_a[7:2]][8*k +: 8] = acc_wd[8*k +: 8];
      if (acc && !acc_we) begin pend = 1; pa = acc_a[7:2]; cnt = rv_fix >= 0 ? rv_fix : $urandom_range(0, 3); end
      if (pend) begin
        if (cnt == 0) begin bus.dmem_rvalid = 1; bus.dmem_rdata = mem_w[pa]; pend = 0; end
        else begin cnt--; bus.dmem_rvalid = 0; bus.dmem_rdata = $urandom; end
      end else begin
        bus.dmem_rvalid = spur && $urandom_range(0, 3) == 0;
        bus.dmem_rdata = $urandom;
      end
      gnt_en = gnt_hold > 0 ? 1'b0 : gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (gnt_hold > 0) gnt_hold--;
    end
  end
  // monitor: pops the scoreboard on every completion/rejection and checks every bus request cycle
  always @(negedge clk) if (rst_n) begin
    if (misaligned || resp_valid) begin
      ev_cnt++;
      resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_event: got mis=%0b resp=%0b expected none", misaligned, resp_valid);
      end else begin
        me = exp_q.pop_front();
        chk("event_misaligned", 32'(misaligned), 32'(me.mis));
        chk("event_resp_valid", 32'(resp_valid), 32'(!me.mis));
        chk("stall_at_event", 32'(stall), 0);
        if (!me.mis) chk("load_data", load_data, me.data);
      end
    end
    if (bus.dmem_req) begin
      chk("stall_in_req", 32'(stall), 1);
      if (bus_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_req: got addr=%h expected no request", bus.dmem_addr);
      end else begin
        mb = bus_q[0];
        chk("bus_we", 32'(bus.dmem_we), 32'(mb.we));
        chk("bus_addr", bus.dmem_addr, mb.a);
        chk("bus_be", 32'(bus.dmem_be), 32'(mb.be));
        if (mb.we) chk("bus_wdata", bus.dmem_wdata, mb.wd);
        if (bus.dmem_gnt) void'(bus_q.pop_front());
      end
    end
  end
  task automatic issue(input bit v, input bit w, input logic [1:0] st, input bit ld, input logic [2:0] lt,
                       input logic [31:0] a, input logic [31:0] sd, input bit wt, output int lat);
    bit is_st, mem, al;
    int sz, off, base, t0, c0;
    logic [31:0] val, wd;
    logic [3:0] be;
    is_st = w && st != STORE_DEF && !ld;
    mem = v && (ld || is_st);
    off = int'(a[1:0]);
    base = int'(a[7:0]) & 252;
    if (ld) sz = (lt == LOAD_LB || lt == LOAD_LBU) ? 1 : (lt == LOAD_LH || lt == LOAD_LHU) ? 2 : 4;
    else sz = st == STORE_SB ? 1 : st == STORE_SH ? 2 : 4;
    al = (off % sz) == 0;
    lat = -1;
    if (mem && !al) exp_q.push_back('{1'b1, 32'h0});
    else if (mem && is_st) begin
      be = 0; wd = 0;
      for (int i = 0; i < 4; i++) begin
        wd[8*i +: 8] = sd[8*(i % sz) +: 8];
        if (i >= off && i < off + sz) begin be[i] = 1; ref_b[base + i] = sd[8*(i - off) +: 8]; end
      end
      bus_q.push_back('{1'b1, a & ~32'h3, be, wd});
      exp_q.push_back('{1'b0, last_ld});
    end else if (mem) begin
      val = 0;
      for (int i = 0; i < sz; i++) val[8*i +: 8] = ref_b[base + off + i];
      if ((lt == LOAD_LB || lt == LOAD_LH) && val[8*sz-1]) for (int i = sz; i < 4; i++) val[8*i +: 8] = 8'hff;
      bus_q.push_back('{1'b0, a & ~32'h3, 4'hf, 32'h0});
      exp_q.push_back('{1'b0, val});
      last_ld = val;
    end
    @(posedge clk); #1;
    in_valid = v; mem_write = w; mem_store_type = st; wb_load = ld; mem_load_type = lt; addr = a; store_data = sd;
    t0 = cyc; c0 = ev_cnt;
    @(negedge clk);
    chk("stall_accept", 32'(stall), 32'(mem && al));
    @(posedge clk); #1;
    in_valid = 0; mem_write = 1'($urandom); wb_load = 1'($urandom); addr = $urandom; store_data = $urandom;
    if (mem && wt) begin
      for (int i = 0; i < 200 && ev_cnt == c0; i++) @(negedge clk);
      if (ev_cnt == c0) begin
        n_chk++; n_err++;
        $display("FAIL timeout: got no response expected one within 200 cycles");
      end else lat = resp_cyc - t0;
    end
  endtask
  initial begin
    int lat, c0;
    logic [2:0] lts[6] = '{LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU, LOAD_DEF};
    for (int i = 0; i < 64; i++) begin
      mem_w[i] = $urandom;
      for (int k = 0; k < 4; k++) ref_b[4*i + k] = mem_w[i][8*k +: 8];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_misaligned", 32'(misaligned), 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_req", 32'(bus.dmem_req), 0);
    chk("rst_we", 32'(bus.dmem_we), 0);
    chk("rst_addr", bus.dmem_addr, 0);
    chk("rst_be", 32'(bus.dmem_be), 0);
    chk("rst_wdata", bus.dmem_wdata, 0);
    @(posedge clk); #1 rst_n = 1;
    issue(1, 1, STORE_SB, 0, 0, 32'h1003, 32'h000000AB, 1, lat);
    chk("sb_latency", lat, 2);
    issue(1, 1, STORE_SW, 0, 0, 32'h2000, 32'h123480FF, 1, lat);
    rv_fix = 3;
    issue(1, 0, 0, 1, LOAD_LB, 32'h2001, 0, 1, lat);
    chk("lb_latency_3wait", lat, 6);
    chk("lb_value", load_data, 32'hFFFFFF80);
    rv_fix = 0;
    issue(1, 0, 0, 1, LOAD_LBU, 32'h2001, 0, 1, lat);
    chk("lbu_latency", lat, 3);
    chk("lbu_value", load_data, 32'h00000080);
    issue(1, 1, STORE_SW, 0, 0, 32'h2000, 32'h80010000, 1, lat);
    issue(1, 0, 0, 1, LOAD_LH, 32'h2002, 0, 1, lat);
    chk("lh_value", load_data, 32'hFFFF8001);
    issue(1, 0, 0, 1, LOAD_LHU, 32'h2002, 0, 1, lat);
    chk("lhu_value", load_data, 32'h00008001);
    issue(1, 1, STORE_SH, 0, 0, 32'h2002, 32'h00005566, 1, lat);
    chk("lhu_held_after_store", load_data, 32'h00008001);
    issue(1, 0, 0, 1, LOAD_LW, 32'h2000, 0, 1, lat);
    chk("lw_after_sh", load_data, 32'h55660000);
    issue(1, 0, 0, 1, LOAD_LW, 32'h3002, 0, 1, lat);
    chk("mis_lw_latency", lat, 0);
    issue(1, 1, STORE_SH, 0, 0, 32'h3001, 32'h1234, 1, lat);
    chk("mis_sh_latency", lat, 0);
    issue(1, 1, STORE_DEF, 0, 0, 32'h3000, 32'h1, 1, lat);
    issue(1, 1, STORE_SW, 1, LOAD_LBU, 32'h2003, 32'hDEADBEEF, 1, lat);
    chk("load_wins_value", load_data, 32'h00000055);
    gnt_hold = 5;
    issue(1, 1, STORE_SW, 0, 0, 32'h2004, 32'hCAFEF00D, 1, lat);
    chk("gnt_stall_latency", lat, 6);
    rv_fix = 5;
    issue(1, 0, 0, 1, LOAD_LW, 32'h2004, 0, 0, lat);
    @(posedge clk); #1;
    rst_n = 0;
    exp_q.delete();
    last_ld = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("rst_mid_load_data", load_data, 0);
    chk("rst_mid_stall", 32'(stall), 0);
    chk("rst_mid_req", 32'(bus.dmem_req), 0);
    c0 = ev_cnt;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_resp", ev_cnt, c0);
    chk("rst_mid_data_after_rvalid", load_data, 0);
    rv_fix = -1; gnt_rand = 1; spur = 1;
    for (int n = 0; n < 250; n++)
      issue(1'($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom), 1'($urandom_range(0, 2) == 0),
            lts[$urandom_range(0, 5)], 32'h1000 | 32'($urandom_range(0, 255)), $urandom, 1, lat);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("bus_queue_drained", bus_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
